// File: rtl/register_file_param_pkg.sv
// register_file_param_pkg: shared defaults, read-latency encodings and address-width helper
package register_file_param_pkg;

    localparam int RF_WIDTH_DEF = 16;
    localparam int RF_DEPTH_DEF = 8;

    localparam int RD_COMB = 0;
    localparam int RD_REG  = 1;

    function automatic int rf_aw(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/register_file_param_register_cell.sv
// register_cell: one WIDTH-bit load/clear register of the bank, clear wins over load
module register_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_ld,
    input  logic             c_clr,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // storage: async active-low reset, then clear, then load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q_q <= '0;
        else if (c_clr) q_q <= '0;
        else if (c_ld) q_q <= d_in;
    end

    assign q = q_q;

endmodule

// File: rtl/register_file_param.sv
// register_file_param: DEPTH x WIDTH register bank, 1 write / 2 read ports, bank clear, bypass
module register_file_param
    import register_file_param_pkg::*;
#(
    parameter  int WIDTH    = RF_WIDTH_DEF,
    parameter  int DEPTH    = RF_DEPTH_DEF,
    parameter  int READ_LAT = RD_COMB,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 0,
    localparam int AW       = rf_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_ld,
    input  logic             c_clr,
    input  logic [AW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_data,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic [DEPTH-1:0] written,
    output logic             w_err
);

    logic [WIDTH-1:0]          ent [DEPTH];
    logic [DEPTH-1:0]          we;
    logic [DEPTH-1:0]          written_q, written_d;
    logic                      w_err_q, w_err_d;
    logic                      w_ok;
    logic [1:0][AW-1:0]        rd_addr;
    logic [1:0][WIDTH-1:0]     rd_d;

    // a write lands only inside the bank and never on the hardwired zero entry
    assign w_ok      = (int'(w_addr) < DEPTH) && !(ZERO_REG != 0 && w_addr == '0);
    assign w_err_d   = c_ld && !c_clr && !w_ok;
    assign written_d = c_clr ? '0 : (written_q | we);
    assign rd_addr   = {rb_addr, ra_addr};

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        assign we[i] = c_ld && !c_clr && w_ok && (w_addr == AW'(i));
        register_cell #(.WIDTH(WIDTH)) u_cell (
            .clk  (clk),
            .reset(reset),
            .c_ld (we[i]),
            .c_clr(c_clr),
            .d_in (w_data),
            .q    (ent[i])
        );
    end

    // bookkeeping: written flags and one-cycle dropped-write pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            written_q <= '0;
            w_err_q   <= '0;
        end else begin
            written_q <= written_d;
            w_err_q   <= w_err_d;
        end
    end

    // read muxes: out-of-range and zero entry read 0, optional forwarding of this cycle's write/clear
    always_comb begin
        rd_d = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++)
                if (rd_addr[p] == AW'(i) && !(ZERO_REG != 0 && i == 0))
                    rd_d[p] = (BYPASS != 0 && we[i]) ? w_data : ent[i];
            if (BYPASS != 0 && c_clr) rd_d[p] = '0;
        end
    end

    if (READ_LAT == RD_REG) begin : g_rd_reg
        logic [1:0][WIDTH-1:0] rd_q;
        // registered read: captures the combinational read value at the edge
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) rd_q <= '0;
            else rd_q <= rd_d;
        end
        assign {rb_data, ra_data} = rd_q;
    end else begin : g_rd_comb
        assign {rb_data, ra_data} = rd_d;
    end

    assign written = written_q;
    assign w_err   = w_err_q;

endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: scoreboard bench over 8 configurations (DEPTH 8/6, READ_LAT 0/1, BYPASS 0/1)
module tb_register_file_param;

    typedef struct {
        int          cyc;
        int          tn;
        int          g;
        int          sig;
        logic [15:0] exp;
    } exp_t;

    logic        clk = 0;
    logic        reset;
    logic        c_ld, c_clr;
    logic [2:0]  w_addr, ra_addr, rb_addr;
    logic [15:0] w_data;
    logic [15:0] ra [8];
    logic [15:0] rb [8];
    logic [7:0]  wr [8];
    logic        er [8];

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // index k: bit2 = DEPTH 6 with zero register, bit1 = READ_LAT, bit0 = BYPASS
    for (genvar k = 0; k < 8; k++) begin : g_dut
        localparam int DEP = (k >= 4) ? 6 : 8;
        logic [DEP-1:0] wv;
        register_file_param #(
            .WIDTH(16), .DEPTH(DEP), .READ_LAT((k >> 1) & 1), .BYPASS(k & 1), .ZERO_REG(k >> 2)
        ) u_dut (
            .clk(clk), .reset(reset), .c_ld(c_ld), .c_clr(c_clr),
            .w_addr(w_addr), .w_data(w_data), .ra_addr(ra_addr), .rb_addr(rb_addr),
            .ra_data(ra[k]), .rb_data(rb[k]), .written(wv), .w_err(er[k])
        );
        assign wr[k] = 8'(wv);
    end

    function automatic int lat_of(int g); return (g >> 1) & 1; endfunction
    function automatic bit byp_of(int g); return (g & 1) != 0; endfunction
    function automatic bit d6_of(int g);  return g >= 4; endfunction

    function automatic logic [15:0] actual(int g, int s);
        return s == 0 ? ra[g] : s == 1 ? rb[g] : s == 2 ? {8'h00, wr[g]} : {15'h0, er[g]};
    endfunction

    function automatic string sname(int s);
        return s == 0 ? "ra_data" : s == 1 ? "rb_data" : s == 2 ? "written" : "w_err";
    endfunction

    task automatic push(int tn, int g, int sig, int dly, logic [15:0] v);
        exp_t e;
        e.cyc = cyc + dly; e.tn = tn; e.g = g; e.sig = sig; e.exp = v;
        sbq.push_back(e);
    endtask

    task automatic exp_rd(int tn, int g, int sig, logic [15:0] v);
        push(tn, g, sig, lat_of(g), v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit ld, bit clr, int a, logic [15:0] d, int ra_a, int rb_a);
        c_ld = ld; c_clr = clr; w_addr = 3'(a); w_data = d; ra_addr = 3'(ra_a); rb_addr = 3'(rb_a);
    endtask

    // monitor: compare every expectation that falls due on this cycle
    always @(negedge clk) begin : mon
        exp_t        keep[$];
        logic [15:0] act;
        keep = {};
        foreach (sbq[i]) begin
            if (sbq[i].cyc == cyc) begin
                act = actual(sbq[i].g, sbq[i].sig);
                n_tests++;
                if (act !== sbq[i].exp) begin
                    n_fail++;
                    $display("FAIL T%0d dut%0d %s cyc %0d: got %h expected %h",
                             sbq[i].tn, sbq[i].g, sname(sbq[i].sig), cyc, act, sbq[i].exp);
                end
            end else if (sbq[i].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL T%0d dut%0d %s stale expectation for cyc %0d", sbq[i].tn, sbq[i].g,
                         sname(sbq[i].sig), sbq[i].cyc);
            end else keep.push_back(sbq[i]);
        end
        sbq = keep;
    end

    initial begin
        reset = 0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        for (int g = 0; g < 8; g++) for (int s = 0; s < 4; s++) push(0, g, s, 0, 0);
        tick(); reset = 1;
        // T1: load entry 3, then assert reset mid-cycle
        tick(); drive(1, 0, 3, 16'hBEEF, 3, 3);
        tick(); drive(0, 0, 0, 0, 3, 3);
        for (int g = 0; g < 8; g++) begin
            push(1, g, 2, 0, 16'h0008);
            if (lat_of(g) == 0) begin
                push(1, g, 0, 0, 16'hBEEF);
                push(1, g, 1, 0, 16'hBEEF);
            end
        end
        tick(); reset = 0;
        for (int g = 0; g < 8; g++) for (int s = 0; s < 4; s++) push(1, g, s, 0, 0);
        tick(); reset = 1; drive(0, 0, 0, 0, 0, 0);
        // T2: load/read
        tick(); drive(1, 0, 5, 16'h1234, 0, 0);
        tick(); drive(1, 0, 2, 16'hABCD, 0, 0);
        tick(); drive(0, 0, 0, 0, 5, 2);
        for (int g = 0; g < 8; g++) begin
            exp_rd(2, g, 0, 16'h1234);
            exp_rd(2, g, 1, 16'hABCD);
            push(2, g, 2, 0, 16'h0024);
            push(2, g, 3, 0, 0);
        end
        // T3: bypass against an old value of 0x1111
        tick(); drive(1, 0, 4, 16'h1111, 0, 0);
        tick(); drive(1, 0, 4, 16'h00FF, 4, 4);
        for (int g = 0; g < 8; g++) exp_rd(3, g, 0, byp_of(g) ? 16'h00FF : 16'h1111);
        tick(); drive(0, 0, 0, 0, 4, 4);
        for (int g = 0; g < 8; g++) begin
            exp_rd(3, g, 0, 16'h00FF);
            exp_rd(3, g, 1, 16'h00FF);
        end
        // T4: clear beats load
        tick(); drive(1, 1, 1, 16'h5555, 1, 5);
        for (int g = 0; g < 8; g++) begin
            exp_rd(4, g, 0, 16'h0000);
            exp_rd(4, g, 1, byp_of(g) ? 16'h0000 : 16'h1234);
        end
        tick(); drive(0, 0, 0, 0, 1, 5);
        for (int g = 0; g < 8; g++) begin
            exp_rd(4, g, 0, 0);
            exp_rd(4, g, 1, 0);
            push(4, g, 2, 0, 0);
            push(4, g, 3, 0, 0);
        end
        // T5: out-of-range write (DEPTH 6) and zero-register write
        tick(); drive(1, 0, 7, 16'hABCD, 7, 7);
        for (int g = 0; g < 8; g++)
            exp_rd(5, g, 0, d6_of(g) ? 16'h0000 : (byp_of(g) ? 16'hABCD : 16'h0000));
        tick(); drive(0, 0, 0, 0, 7, 7);
        for (int g = 0; g < 8; g++) begin
            exp_rd(5, g, 0, d6_of(g) ? 16'h0000 : 16'hABCD);
            push(5, g, 3, 0, d6_of(g) ? 16'h0001 : 16'h0000);
            push(5, g, 2, 0, d6_of(g) ? 16'h0000 : 16'h0080);
        end
        tick(); drive(1, 0, 0, 16'hCAFE, 0, 0);
        for (int g = 0; g < 8; g++) begin
            push(5, g, 3, 0, 0);
            exp_rd(5, g, 0, d6_of(g) ? 16'h0000 : (byp_of(g) ? 16'hCAFE : 16'h0000));
        end
        tick(); drive(0, 0, 0, 0, 0, 0);
        for (int g = 0; g < 8; g++) begin
            exp_rd(5, g, 0, d6_of(g) ? 16'h0000 : 16'hCAFE);
            push(5, g, 3, 0, d6_of(g) ? 16'h0001 : 16'h0000);
            push(5, g, 2, 0, d6_of(g) ? 16'h0000 : 16'h0081);
        end
        tick();
        for (int g = 0; g < 8; g++) push(5, g, 3, 0, 0);
        // T6: dual read of the same entry while idle
        tick(); drive(1, 0, 3, 16'h7E7E, 0, 0);
        for (int n = 0; n < 10; n++) begin
            tick(); drive(0, 0, 0, 0, 3, 3);
            for (int g = 0; g < 8; g++) begin
                exp_rd(6, g, 0, 16'h7E7E);
                exp_rd(6, g, 1, 16'h7E7E);
                push(6, g, 2, 0, d6_of(g) ? 16'h0008 : 16'h0089);
            end
        end
        repeat (3) tick();
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
